ram_pattern_engine: RTL and testbench

//  Parametrised RAM fill/verify engine for the RC4 datapath. Sweeps a runtime address range,

---
 rtl/rc4_init_pkg.sv | 6 +
 rtl/verify_delay_line.sv | 24 ++
 rtl/ram_pattern_engine.sv | 148 ++++++++++++++
 tb/tb_ram_pattern_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_init_pkg.sv
// rc4_init_pkg: shared types and limits for the RAM fill/verify engine.
package rc4_init_pkg;
  typedef enum logic [1:0] {IDENTITY, CONST, STRIDE, VERIFY} mode_t;
  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN} state_t;
  localparam int MAX_READ_LATENCY = 4;
endpackage

// File: rtl/verify_delay_line.sv
// verify_delay_line: carries {valid, expected, address} so it lines up with RAM read data.
module verify_delay_line #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] exp_o,
  output logic [ADDR_W-1:0] addr_o
);
  localparam int W  = 1 + DATA_W + ADDR_W;
  localparam int SW = READ_LATENCY * W;
  logic [SW-1:0] sr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else        sr_q <= flush_i ? '0 : SW'({sr_q, valid_i, exp_i, addr_i});
  assign {valid_o, exp_o, addr_o} = sr_q[SW-1 -: W];
endmodule

// File: rtl/ram_pattern_engine.sv
// ram_pattern_engine: fills a RAM address range with a pattern or verifies it against a stride.
module ram_pattern_engine
  import rc4_init_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_index,
  input  logic [ADDR_W-1:0] end_index,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mismatch_addr,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  localparam int CNT_W = $clog2(MAX_READ_LATENCY);
  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic              start_q, we_q, we_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d, mm_q, mm_d, next_addr, chk_addr;
  logic [DATA_W-1:0] data_q, data_d, seed_q, seed_d, step_q, step_d, next_data, chk_exp;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_pulse, last, chk_valid, mismatch;

  verify_delay_line #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(READ_LATENCY)) u_dl (
    .clk(clk), .rst_n(reset), .flush_i(state_q == IDLE), .valid_i(state_q == RD_ISSUE),
    .exp_i(data_q), .addr_i(addr_q), .valid_o(chk_valid), .exp_o(chk_exp), .addr_o(chk_addr)
  );

  assign start_pulse = start & ~start_q;
  assign busy        = state_q != IDLE;
  assign last        = addr_q == end_q;
  assign next_addr   = addr_q + 1'b1;
  assign next_data   = mode_q == IDENTITY ? DATA_W'(next_addr) : mode_q == CONST ? seed_q : data_q + step_q;
  assign mismatch    = busy && chk_valid && chk_exp != ram_out;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    end_d   = end_q;
    seed_d  = seed_q;
    step_d  = step_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    done_d  = done_q;
    err_d   = err_q;
    mm_d    = mm_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start_pulse && !abort) begin
        mode_d  = mode_t'(mode);
        end_d   = end_index;
        seed_d  = seed;
        step_d  = step;
        addr_d  = start_index;
        data_d  = mode == IDENTITY ? DATA_W'(start_index) : seed;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we_d    = mode != VERIFY;
        state_d = mode == VERIFY ? RD_ISSUE : WRITE;
      end
      WRITE: if (last) begin
        we_d    = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        addr_d = next_addr;
        data_d = next_data;
      end
      RD_ISSUE: if (last) begin
        state_d = RD_DRAIN;
        cnt_d   = CNT_W'(READ_LATENCY - 1);
      end else begin
        addr_d = next_addr;
        data_d = next_data;
      end
      RD_DRAIN: if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    if (mismatch) begin
      err_d   = 1'b1;
      mm_d    = chk_addr;
      done_d  = 1'b1;
      state_d = IDLE;
    end
    // abort beats both completion and a same-cycle mismatch
    if (abort && busy) begin
      state_d = IDLE;
      we_d    = 1'b0;
      done_d  = done_q;
      err_d   = err_q;
      mm_d    = mm_q;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= IDENTITY;
      start_q <= 1'b0;
      end_q   <= '0;
      seed_q  <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mm_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start;
      end_q   <= end_d;
      seed_q  <= seed_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mm_q    <= mm_d;
      cnt_q   <= cnt_d;
    end

  assign done          = done_q;
  assign error         = err_q;
  assign mismatch_addr = mm_q;
  assign write_enable  = we_q;
  assign address       = addr_q;
  assign ram_in        = data_q;
endmodule

// File: tb/tb_ram_pattern_engine.sv
// tb_ram_pattern_engine: directed tests for the fill/verify engine at read latency 1 and 3.
module tb_ram_pattern_engine;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, corrupt = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] si = '0, ei = '0, seed = '0, step = '0;
  logic       busy1, done1, err1, we1, busy3, done3, err3, we3;
  logic [7:0] mm1, a1, din1, mm3, a3, din3, q1, q3a, q3b, q3c;
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] wa [300];
  logic [7:0] wd [300];
  int nw, tests = 0, fails = 0;

  always #5 clk = ~clk;

  ram_pattern_engine #(.DATA_W(8), .ADDR_W(8), .READ_LATENCY(1)) u1 (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .mode(mode), .start_index(si),
    .end_index(ei), .seed(seed), .step(step), .busy(busy1), .done(done1), .error(err1),
    .mismatch_addr(mm1), .write_enable(we1), .address(a1), .ram_in(din1), .ram_out(q1));
  ram_pattern_engine #(.DATA_W(8), .ADDR_W(8), .READ_LATENCY(3)) u3 (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .mode(mode), .start_index(si),
    .end_index(ei), .seed(seed), .step(step), .busy(busy3), .done(done3), .error(err3),
    .mismatch_addr(mm3), .write_enable(we3), .address(a3), .ram_in(din3), .ram_out(q3c));

  // RAM models; corrupt forces a bad byte at 0x10 on the read path
  always @(posedge clk) begin
    if (we1) mem1[a1] <= din1;
    q1 <= (corrupt && a1 == 8'h10) ? 8'hEE : mem1[a1];
  end
  always @(posedge clk) begin
    if (we3) mem3[a3] <= din3;
    q3a <= (corrupt && a3 == 8'h10) ? 8'hEE : mem3[a3];
    q3b <= q3a;
    q3c <= q3b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [1:0] m, input logic [7:0] s, e, sd, st);
    mode = m; si = s; ei = e; seed = sd; step = st; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic collect_writes();
    nw = 0;
    while (we1 && nw < 300) begin
      wa[nw] = a1; wd[nw] = din1; nw++;
      tick();
    end
  endtask

  task automatic test_reset();
    tests++; if ({busy1, done1, err1, we1} !== 4'b0) begin fails++; $display("FAIL reset_flags1: got %b want 0000", {busy1, done1, err1, we1}); end
    tests++; if ({a1, din1, mm1} !== 24'h0) begin fails++; $display("FAIL reset_bus1: got %h want 000000", {a1, din1, mm1}); end
    tests++; if ({busy3, done3, err3, we3, a3, din3, mm3} !== 28'h0) begin fails++; $display("FAIL reset_all3: got %h want 0", {busy3, done3, err3, we3, a3, din3, mm3}); end
  endtask

  task automatic test_identity();
    kick(2'd0, 8'd0, 8'd255, 8'd0, 8'd0);
    tests++; if ({we1, busy1, done1} !== 3'b110) begin fails++; $display("FAIL id_first: we/busy/done got %b want 110", {we1, busy1, done1}); end
    collect_writes();
    tests++; if (nw !== 256) begin fails++; $display("FAIL id_count: got %0d want 256", nw); end
    for (int i = 0; i < 256; i++) begin
      tests++; if (wa[i] !== 8'(i) || wd[i] !== 8'(i)) begin fails++; $display("FAIL id_elem %0d: got a=%h d=%h want %h", i, wa[i], wd[i], 8'(i)); end
    end
    tests++; if ({done1, busy1, we1} !== 3'b100) begin fails++; $display("FAIL id_done: done/busy/we got %b want 100", {done1, busy1, we1}); end
    tests++; if ({done3, busy3} !== 2'b10) begin fails++; $display("FAIL id_done3: done/busy got %b want 10", {done3, busy3}); end
  endtask

  task automatic test_verify_error();
    int n1 = 0, n3 = 0;
    logic [7:0] m1 = '0, m3 = '0;
    logic wseen = 1'b0;
    corrupt = 1'b1;
    kick(2'd3, 8'd0, 8'd255, 8'd0, 8'd1);
    for (int c = 0; c < 400 && (busy1 || busy3); c++) begin
      if (busy1) begin n1++; if (a1 > m1) m1 = a1; end
      if (busy3) begin n3++; if (a3 > m3) m3 = a3; end
      wseen = wseen | we1 | we3;
      tick();
    end
    tests++; if (n1 !== 18) begin fails++; $display("FAIL verr_cycles1: got %0d want 18", n1); end
    tests++; if (n3 !== 20) begin fails++; $display("FAIL verr_cycles3: got %0d want 20", n3); end
    tests++; if (m1 !== 8'h11) begin fails++; $display("FAIL verr_maxaddr1: got %h want 11", m1); end
    tests++; if (m3 !== 8'h13) begin fails++; $display("FAIL verr_maxaddr3: got %h want 13", m3); end
    tests++; if (wseen !== 1'b0) begin fails++; $display("FAIL verr_we: got %b want 0", wseen); end
    tests++; if ({err1, done1, busy1, mm1} !== {3'b110, 8'h10}) begin fails++; $display("FAIL verr_result1: err/done/busy/mm got %b/%b/%b/%h want 1/1/0/10", err1, done1, busy1, mm1); end
    tests++; if ({err3, done3, busy3, mm3} !== {3'b110, 8'h10}) begin fails++; $display("FAIL verr_result3: err/done/busy/mm got %b/%b/%b/%h want 1/1/0/10", err3, done3, busy3, mm3); end
    corrupt = 1'b0;
  endtask

  task automatic test_verify_clean();
    int n1 = 0, n3 = 0;
    kick(2'd3, 8'd0, 8'd31, 8'd0, 8'd1);
    tests++; if ({done1, err1, busy1} !== 3'b001) begin fails++; $display("FAIL vcl_clear: done/err/busy got %b want 001", {done1, err1, busy1}); end
    for (int c = 0; c < 100 && (busy1 || busy3); c++) begin
      if (busy1) n1++;
      if (busy3) n3++;
      tick();
    end
    tests++; if (n1 !== 33) begin fails++; $display("FAIL vcl_cycles1: got %0d want 33", n1); end
    tests++; if (n3 !== 35) begin fails++; $display("FAIL vcl_cycles3: got %0d want 35", n3); end
    tests++; if ({err1, done1, err3, done3} !== 4'b0101) begin fails++; $display("FAIL vcl_result: err1/done1/err3/done3 got %b want 0101", {err1, done1, err3, done3}); end
  endtask

  task automatic test_const_wrap();
    kick(2'd1, 8'd250, 8'd3, 8'hAA, 8'd0);
    collect_writes();
    tests++; if (nw !== 10) begin fails++; $display("FAIL const_count: got %0d want 10", nw); end
    for (int i = 0; i < 10; i++) begin
      tests++; if (wa[i] !== 8'(250 + i) || wd[i] !== 8'hAA) begin fails++; $display("FAIL const_elem %0d: got a=%h d=%h want a=%h d=aa", i, wa[i], wd[i], 8'(250 + i)); end
    end
    tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL const_done: got %b want 1", done1); end
  endtask

  task automatic test_stride();
    logic [7:0] e1 [4] = '{8'h05, 8'h08, 8'h0B, 8'h0E};
    logic [7:0] e2 [4] = '{8'h05, 8'h85, 8'h05, 8'h85};
    kick(2'd2, 8'd0, 8'd3, 8'h05, 8'h03);
    collect_writes();
    tests++; if (nw !== 4) begin fails++; $display("FAIL stride3_count: got %0d want 4", nw); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (wd[i] !== e1[i] || wa[i] !== 8'(i)) begin fails++; $display("FAIL stride3_elem %0d: got a=%h d=%h want a=%h d=%h", i, wa[i], wd[i], 8'(i), e1[i]); end
    end
    kick(2'd2, 8'd0, 8'd3, 8'h05, 8'h80);
    collect_writes();
    tests++; if (nw !== 4) begin fails++; $display("FAIL stride80_count: got %0d want 4", nw); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (wd[i] !== e2[i]) begin fails++; $display("FAIL stride80_elem %0d: got %h want %h", i, wd[i], e2[i]); end
    end
  endtask

  task automatic test_back_to_back();
    kick(2'd1, 8'd0, 8'd9, 8'h11, 8'd0);
    mode = 2'd0; seed = 8'h55; ei = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    collect_writes();
    tests++; if (nw !== 9 || wa[0] !== 8'd1 || wa[8] !== 8'd9) begin fails++; $display("FAIL busy_start_range: got n=%0d first=%h last=%h want 9/01/09", nw, wa[0], wa[8]); end
    for (int i = 0; i < 9; i++) begin
      tests++; if (wd[i] !== 8'h11) begin fails++; $display("FAIL busy_start_data %0d: got %h want 11", i, wd[i]); end
    end
    tests++; if ({done1, busy1} !== 2'b10) begin fails++; $display("FAIL busy_start_done: done/busy got %b want 10", {done1, busy1}); end
  endtask

  task automatic test_abort();
    kick(2'd0, 8'd0, 8'd255, 8'd0, 8'd0);
    repeat (4) tick();
    tests++; if ({we1, a1} !== {1'b1, 8'd4}) begin fails++; $display("FAIL abort_pre: we/addr got %b/%h want 1/04", we1, a1); end
    abort = 1'b1;
    tick();
    tests++; if ({we1, busy1, done1, err1} !== 4'b0000) begin fails++; $display("FAIL abort_stop: we/busy/done/err got %b want 0000", {we1, busy1, done1, err1}); end
    abort = 1'b0;
    tick();
    tests++; if ({busy1, we1, busy3} !== 3'b000) begin fails++; $display("FAIL abort_idle: busy1/we1/busy3 got %b want 000", {busy1, we1, busy3}); end
    abort = 1'b1;
    kick(2'd1, 8'd0, 8'd3, 8'h77, 8'd0);
    tests++; if ({busy1, we1} !== 2'b00) begin fails++; $display("FAIL abort_start_idle: busy/we got %b want 00", {busy1, we1}); end
    abort = 1'b0;
    tick();
    tests++; if ({busy1, done1} !== 2'b00) begin fails++; $display("FAIL abort_start_after: busy/done got %b want 00", {busy1, done1}); end
  endtask

  task automatic test_reset_mid();
    kick(2'd0, 8'd0, 8'd255, 8'd0, 8'd0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({we1, busy1, done1, a1, din1} !== 19'h0) begin fails++; $display("FAIL rst_mid_async: we/busy/done/addr/data got %b/%b/%b/%h/%h want 0", we1, busy1, done1, a1, din1); end
    mode = 2'd1; seed = 8'h3C; si = 8'd5; ei = 8'd7; start = 1'b1;
    tick();
    tests++; if ({we1, busy1} !== 2'b00) begin fails++; $display("FAIL rst_mid_held: we/busy got %b want 00", {we1, busy1}); end
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    collect_writes();
    tests++; if (nw !== 3 || wa[0] !== 8'd5 || wa[2] !== 8'd7) begin fails++; $display("FAIL rst_restart_range: got n=%0d first=%h last=%h want 3/05/07", nw, wa[0], wa[2]); end
    tests++; if (wd[0] !== 8'h3C || wd[1] !== 8'h3C || wd[2] !== 8'h3C) begin fails++; $display("FAIL rst_restart_data: got %h %h %h want 3c", wd[0], wd[1], wd[2]); end
    tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL rst_restart_done: got %b want 1", done1); end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_identity();
    test_verify_error();
    test_verify_clean();
    test_const_wrap();
    test_stride();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
